// File: rtl/p_beid_interconnect_f0_ahb_mtx_pkg.sv
// Shared bus-matrix definitions.
// AHB encodings and burst length lookup.
package p_beid_interconnect_f0_ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'b000,
    HB_INCR   = 3'b001,
    HB_WRAP4  = 3'b010,
    HB_INCR4  = 3'b011,
    HB_WRAP8  = 3'b100,
    HB_INCR8  = 3'b101,
    HB_WRAP16 = 3'b110,
    HB_INCR16 = 3'b111
  } hburst_e;

  // Beats remaining after the NONSEQ beat.
  // INCR has no length; caller supplies its cap.
  function automatic logic [3:0] burst_remain(
    input logic [2:0] hburst,
    input logic [3:0] incr_m1
  );
    logic [3:0] r;
    r = '0;
    unique case (hburst)
      HB_SINGLE: r = 4'd0;
      HB_INCR:   r = incr_m1;
      HB_WRAP4:  r = 4'd3;
      HB_INCR4:  r = 4'd3;
      HB_WRAP8:  r = 4'd7;
      HB_INCR8:  r = 4'd7;
      HB_WRAP16: r = 4'd15;
      HB_INCR16: r = 4'd15;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/p_beid_interconnect_f0_ahb_mtx_qos_arbiter_if.sv
// Slave-port arbiter bundle.
// master drives requests and bus state; slave returns the grant.
interface p_beid_interconnect_f0_ahb_mtx_qos_arbiter_if #(
  parameter int NPORTS = 4,
  parameter int PW     = 2
);
  logic [NPORTS-1:0] req_port;
  logic [NPORTS-1:0] prio_hi;
  logic              HREADYM;
  logic              HSELM;
  logic [1:0]        HTRANSM;
  logic [2:0]        HBURSTM;
  logic              HMASTLOCKM;
  logic [PW-1:0]     addr_in_port;
  logic              no_port;
  logic              grant_chg;

  modport master (
    output req_port, prio_hi, HREADYM, HSELM,
    output HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, grant_chg
  );

  modport slave (
    input  req_port, prio_hi, HREADYM, HSELM,
    input  HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, grant_chg
  );
endinterface

// File: rtl/p_beid_interconnect_f0_ahb_mtx_rr_pick.sv
// Round-robin picker.
// First set candidate at or after start, wrapping.
module p_beid_interconnect_f0_ahb_mtx_rr_pick #(
  parameter int NPORTS = 4,
  parameter int PW     = 2
) (
  input  logic [NPORTS-1:0] cand,
  input  logic [PW-1:0]     start,
  output logic              found,
  output logic [PW-1:0]     idx
);

  // Scan farthest first so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      logic [PW-1:0] j;
      j = PW'((int'(start) + i) % NPORTS);
      if (cand[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/p_beid_interconnect_f0_ahb_mtx_qos_arbiter.sv
// Bus-matrix slave-port output-stage arbiter.
// Two-class round-robin with burst/lock grant hold.
module p_beid_interconnect_f0_ahb_mtx_qos_arbiter
  import p_beid_interconnect_f0_ahb_mtx_pkg::*;
#(
  parameter int NPORTS    = 4,
  parameter int PW        = 2,
  parameter int INCR_HOLD = 4
) (
  input logic HCLK,
  input logic HRESETn,
  p_beid_interconnect_f0_ahb_mtx_qos_arbiter_if.slave bus
);

  localparam logic [3:0] INCR_M1 = 4'(INCR_HOLD - 1);
  localparam logic [PW-1:0] LAST = PW'(NPORTS - 1);

  logic [3:0]        remain;
  logic [3:0]        next_remain;
  logic              hold;
  logic              next_hold;
  logic [PW-1:0]     grant_q;
  logic [PW-1:0]     next_addr;
  logic              no_port_q;
  logic              next_no_port;
  logic              grant_chg_q;
  logic [NPORTS-1:0] hi_req;
  logic [NPORTS-1:0] cand;
  logic [PW-1:0]     start;
  logic              pick_found;
  logic [PW-1:0]     pick_idx;

  assign bus.addr_in_port = grant_q;
  assign bus.no_port      = no_port_q;
  assign bus.grant_chg    = grant_chg_q;

  // Beats still owed to the current burst.
  always_comb begin
    next_remain = remain;
    if (!bus.HSELM) begin
      next_remain = '0;
    end else begin
      unique case (bus.HTRANSM)
        HT_IDLE:   next_remain = '0;
        HT_BUSY:   next_remain = remain;
        HT_NONSEQ: next_remain = burst_remain(bus.HBURSTM, INCR_M1);
        HT_SEQ:    next_remain = hold ? remain - 4'd1 : '0;
        default:   next_remain = 'x;
      endcase
    end
  end

  assign next_hold = (next_remain != 4'd0);

  // High class pre-empts low class at every arbitration point.
  assign hi_req = bus.req_port & bus.prio_hi;
  assign cand   = (|hi_req) ? hi_req : bus.req_port;

  // Owner is visited last; with no owner start at port 0.
  always_comb begin
    start = '0;
    if (!no_port_q && grant_q != LAST)
      start = grant_q + 1'b1;
  end

  p_beid_interconnect_f0_ahb_mtx_rr_pick #(
    .NPORTS (NPORTS),
    .PW     (PW)
  ) u_pick (
    .cand  (cand),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next grant; an idle selected slave parks on its owner.
  always_comb begin
    next_addr    = grant_q;
    next_no_port = no_port_q;
    if (bus.HMASTLOCKM || next_hold) begin
      next_addr    = grant_q;
    end else if (pick_found) begin
      next_addr    = pick_idx;
      next_no_port = 1'b0;
    end else if (!(bus.HSELM && !no_port_q)) begin
      next_no_port = 1'b1;
    end
  end

  // State advances only on completed slave transfers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      remain      <= '0;
      hold        <= 1'b0;
      grant_q     <= '0;
      no_port_q   <= 1'b1;
      grant_chg_q <= 1'b0;
    end else begin
      grant_chg_q <= 1'b0;
      if (bus.HREADYM) begin
        remain      <= next_remain;
        hold        <= next_hold;
        grant_q     <= next_addr;
        no_port_q   <= next_no_port;
        grant_chg_q <= (next_addr != grant_q) ||
                       (next_no_port != no_port_q);
      end
    end
  end

endmodule

// File: tb/tb_p_beid_interconnect_f0_ahb_mtx_qos_arbiter.sv
// Directed bench for the slave-port QoS arbiter.
// Expected grants are hand-derived per step.
module tb_p_beid_interconnect_f0_ahb_mtx_qos_arbiter;
  import p_beid_interconnect_f0_ahb_mtx_pkg::*;

  logic HCLK;
  logic HRESETn;
  int   checks = 0;
  int   errors = 0;

  p_beid_interconnect_f0_ahb_mtx_qos_arbiter_if #(
    .NPORTS (4),
    .PW     (2)
  ) bus ();

  p_beid_interconnect_f0_ahb_mtx_qos_arbiter #(
    .NPORTS    (4),
    .PW        (2),
    .INCR_HOLD (4)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(
    input logic [3:0] req,
    input logic [3:0] pri,
    input logic       sel,
    input logic [1:0] tr,
    input logic [2:0] hb,
    input logic       lk
  );
    bus.req_port   = req;
    bus.prio_hi    = pri;
    bus.HSELM      = sel;
    bus.HTRANSM    = tr;
    bus.HBURSTM    = hb;
    bus.HMASTLOCKM = lk;
  endtask

  task automatic chk(
    input string      tag,
    input logic [1:0] ea,
    input logic       en,
    input logic       eg
  );
    checks++;
    assert ({bus.addr_in_port, bus.no_port, bus.grant_chg} === {ea, en, eg})
    else begin
      errors++;
      $error("FAIL %s: got addr=%0d no_port=%0b grant_chg=%0b want addr=%0d no_port=%0b grant_chg=%0b",
             tag, bus.addr_in_port, bus.no_port, bus.grant_chg, ea, en, eg);
    end
  endtask

  initial begin
    HRESETn     = 1'b0;
    bus.HREADYM = 1'b1;
    drv(4'b0000, 4'b0000, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    tick();
    chk("reset", 2'd0, 1'b1, 1'b0);

    drv(4'b0101, 4'b0000, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
    HRESETn = 1'b1;
    tick();
    chk("t1_first_grant", 2'd0, 1'b0, 1'b1);

    drv(4'b0110, 4'b0000, 1'b1, HT_NONSEQ, HB_INCR8, 1'b0);
    tick();
    chk("t2_nonseq", 2'd0, 1'b0, 1'b0);
    drv(4'b0110, 4'b0000, 1'b1, HT_SEQ, HB_INCR8, 1'b0);
    tick();
    chk("t2_seq1", 2'd0, 1'b0, 1'b0);
    tick();
    chk("t2_seq2", 2'd0, 1'b0, 1'b0);
    drv(4'b0110, 4'b0000, 1'b1, HT_BUSY, HB_INCR8, 1'b0);
    tick();
    chk("t2_busy", 2'd0, 1'b0, 1'b0);
    drv(4'b0110, 4'b0000, 1'b1, HT_SEQ, HB_INCR8, 1'b0);
    tick();
    chk("t2_seq3", 2'd0, 1'b0, 1'b0);
    tick();
    chk("t2_seq4", 2'd0, 1'b0, 1'b0);
    tick();
    chk("t2_seq5", 2'd0, 1'b0, 1'b0);
    tick();
    chk("t2_seq6", 2'd0, 1'b0, 1'b0);
    tick();
    chk("t2_release", 2'd1, 1'b0, 1'b1);

    drv(4'b1101, 4'b1000, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    chk("t3_hi_class", 2'd3, 1'b0, 1'b1);
    drv(4'b0010, 4'b0000, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    chk("t3_back_to_1", 2'd1, 1'b0, 1'b1);
    drv(4'b1101, 4'b0000, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    chk("t3_rr_low", 2'd2, 1'b0, 1'b1);

    drv(4'b0101, 4'b0000, 1'b1, HT_NONSEQ, HB_INCR, 1'b0);
    tick();
    chk("t4_beat1", 2'd2, 1'b0, 1'b0);
    drv(4'b0101, 4'b0000, 1'b1, HT_SEQ, HB_INCR, 1'b0);
    tick();
    chk("t4_beat2", 2'd2, 1'b0, 1'b0);
    tick();
    chk("t4_beat3", 2'd2, 1'b0, 1'b0);
    tick();
    chk("t4_beat4_rearb", 2'd0, 1'b0, 1'b1);

    drv(4'b0111, 4'b0000, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b1);
    tick();
    chk("t5_lock1", 2'd0, 1'b0, 1'b0);
    tick();
    chk("t5_lock2", 2'd0, 1'b0, 1'b0);
    drv(4'b0111, 4'b0000, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    chk("t5_unlock", 2'd1, 1'b0, 1'b1);

    drv(4'b0111, 4'b0000, 1'b1, HT_NONSEQ, HB_INCR4, 1'b0);
    tick();
    chk("t5_inc4_b1", 2'd1, 1'b0, 1'b0);
    drv(4'b0111, 4'b0000, 1'b1, HT_SEQ, HB_INCR4, 1'b0);
    tick();
    chk("t5_inc4_b2", 2'd1, 1'b0, 1'b0);
    tick();
    chk("t5_inc4_b3", 2'd1, 1'b0, 1'b0);
    drv(4'b0111, 4'b0000, 1'b1, HT_SEQ, HB_INCR4, 1'b1);
    tick();
    chk("t5_lock_at_end", 2'd1, 1'b0, 1'b0);
    drv(4'b0111, 4'b0000, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    chk("t5_lock_drop", 2'd2, 1'b0, 1'b1);

    drv(4'b0000, 4'b0000, 1'b1, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    chk("park", 2'd2, 1'b0, 1'b0);
    drv(4'b0000, 4'b0000, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    chk("no_port", 2'd2, 1'b1, 1'b1);
    drv(4'b1000, 4'b0000, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    chk("from_no_port", 2'd3, 1'b0, 1'b1);

    bus.HREADYM = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drv(k[0] ? 4'b0001 : 4'b0110, k[0] ? 4'b0001 : 4'b0000,
          1'b1, HT_NONSEQ, HB_INCR16, k[1]);
      tick();
      chk("t6_freeze", 2'd3, 1'b0, 1'b0);
    end
    bus.HREADYM = 1'b1;
    drv(4'b0100, 4'b0000, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
    tick();
    chk("t6_resume", 2'd2, 1'b0, 1'b1);

    drv(4'b0011, 4'b0000, 1'b1, HT_NONSEQ, HB_INCR16, 1'b0);
    tick();
    chk("t6_inc16_b1", 2'd2, 1'b0, 1'b0);
    drv(4'b0011, 4'b0000, 1'b1, HT_SEQ, HB_INCR16, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_inc16_seq", 2'd2, 1'b0, 1'b0);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    chk("t6_async_reset", 2'd0, 1'b1, 1'b0);
    drv(4'b0010, 4'b0000, 1'b1, HT_SEQ, HB_INCR16, 1'b0);
    #2;
    HRESETn = 1'b1;
    tick();
    chk("t6_post_reset", 2'd1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
